audio_sample_scheduler: RTL
===========================

Name: audio_sample_scheduler

Overview:
- Paces audio samples from an upstream producer to a DAC-side consumer at a programmable sample rate.
- Owns the sample-rate divider, with a default of 100 MHz / 2268 ≈ 44.1 kHz.
- Prefetches one sample over a valid/ready handshake and emits it on each rate tick.
- Counts underruns and applies divisor changes only at tick boundaries, so no short or glitched period occurs.

Parameters:
- DIV_W, 16, width of divisor and period counter.
- SAMPLE_W, 16, audio sample width.
- DEFAULT_DIV, 2268, divisor loaded at reset (44.1 kHz at 100 MHz).

Ports:
- clk  in  1  system clock (100 MHz).
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  level; 1 = run the scheduler.
- div_in  in  DIV_W  new divisor (period in clk cycles).
- div_load  in  1  one-cycle pulse; captures div_in.
- div_busy  out  1  a captured divisor is pending and not yet applied.
- s_valid  in  1  producer sample valid.
- s_ready  out  1  scheduler accepts a sample this cycle.
- s_data  in  SAMPLE_W  producer sample.
- sample_out  out  SAMPLE_W  current sample to DAC; held between strobes.
- sample_strobe  out  1  one-cycle pulse when sample_out updates.
- underrun  out  1  one-cycle pulse when a tick finds the buffer empty.
- underrun_count  out  8  saturating underrun counter.
- running  out  1  FSM is in RUN.

Behaviour:
- Reset values: all outputs 0; active divisor = DEFAULT_DIV; buffer empty; FSM = IDLE.
- FSM states: IDLE and RUN.
  - IDLE -> RUN when enable = 1, registered; running goes high the next cycle.
  - RUN -> IDLE when enable = 0, effective the next cycle.
  - Entering IDLE clears the period counter and flushes the buffer. sample_out and underrun_count are retained.
- Period counter (RUN only):
  - Counts 0..div-1 and wraps to 0.
  - The cycle in which count == div-1 is the tick.
  - Period = div cycles exactly.
  - The first tick occurs at count == div-1 after entering RUN, with the counter starting at 0.
- Divisor rules:
  - Values below 2 are clamped to 2.
  - div_load captures div_in into a pending register and sets div_busy.
  - In RUN, the pending value becomes active on the tick cycle (wrap). div_busy clears the cycle after.
  - In IDLE, the pending value is applied immediately; div_busy is high for 1 cycle.
  - A second div_load while pending overwrites the pending value (last wins).
  - div_load on the same cycle as a tick goes to pending and is applied at the next tick.
- Handshake and buffer:
  - s_ready = running AND buffer empty (registered state, so no combinational path from s_valid).
  - A transfer occurs when s_valid && s_ready; data is written to the 1-entry buffer.
- On each tick, sample_strobe and sample_out are registered, so both appear the cycle after the tick:
  - Buffer full at start of tick cycle: sample_out <= buffer, sample_strobe = 1, buffer empties.
  - Buffer empty: sample_out holds, sample_strobe = 0, underrun = 1, underrun_count increments and saturates at 255.
  - A transfer on the tick cycle itself (buffer was empty) still counts as an underrun. The data stays buffered for the next tick.
- underrun_count clears only on rst.
- rst mid-operation: immediate return to reset values, including any pending divisor (discarded).

Decomposition:
- Package audio_pkg holds:
  - DIV_44K1 = 2268, DIV_48K = 2083, DIV_32K = 3125, DIV_MIN = 2.
  - State encoding constants for IDLE and RUN.
- Sub-module sample_rate_divider:
  - Contains the period counter, pending/active divisor registers, clamp logic and the tick output.
  - Inputs: clk, rst, run, div_in, div_load. Outputs: tick, div_busy.
- The top level holds the FSM, the buffer/handshake and the underrun statistics.

Test Plan:
1. Reset, enable = 1, s_valid held 1 with an incrementing s_data -> sample_strobe every 2268 cycles; sample_out = 0, 1, 2, …; underrun_count stays 0.
2. div_load with div_in = 2083 mid-period -> current period still 2268 cycles, next period 2083; div_busy high from load until the cycle after the tick.
3. s_valid = 0 for 3 ticks -> 3 underrun pulses, no strobes, sample_out held, underrun_count = 3. Drive 300 ticks with s_valid = 0 -> underrun_count = 255.
4. div_in = 0 and div_in = 1 -> tick every 2 cycles; s_valid held 1 -> strobe every 2 cycles with no underrun.
5. enable dropped with buffer full, then re-raised -> buffer flushed, s_ready low while IDLE; the first tick after re-enable is div cycles later and uses a newly accepted sample.
6. Assert rst mid-period with a divisor pending -> all outputs 0 asynchronously; after release, period = 2268 and underrun_count = 0.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared constants for the audio sample scheduler.
// Covers the standard divisors at 100 MHz and the FSM state encoding.
package audio_pkg;

  localparam int unsigned DIV_44K1 = 2268;
  localparam int unsigned DIV_48K  = 2083;
  localparam int unsigned DIV_32K  = 3125;
  localparam int unsigned DIV_MIN  = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/audio_sample_scheduler_divider.sv
// Sample-rate divider: period counter plus pending and active divisors.
// A new divisor takes effect only at a wrap, so no period is ever cut short.
module sample_rate_divider
  import audio_pkg::*;
#(
  parameter int unsigned DIV_W       = 16,
  parameter int unsigned DEFAULT_DIV = DIV_44K1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [DIV_W-1:0] div_in,
  input  logic             div_load,
  output logic             tick,
  output logic             div_busy
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] active_div;
  logic [DIV_W-1:0] pending_div;
  logic             pend;
  logic [DIV_W-1:0] div_clamped;

  assign div_clamped = (div_in < DIV_W'(DIV_MIN))
                     ? DIV_W'(DIV_MIN) : div_in;

  assign tick     = run && (cnt == active_div - DIV_W'(1));
  assign div_busy = pend;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      active_div  <= DIV_W'(DEFAULT_DIV);
      pending_div <= DIV_W'(DEFAULT_DIV);
      pend        <= 1'b0;
    end else begin
      if (!run || tick) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + DIV_W'(1);
      end
      // When idle there is no period to protect, so apply at once.
      if (pend && (tick || !run)) begin
        active_div <= pending_div;
        pend       <= 1'b0;
      end
      if (div_load) begin
        pending_div <= div_clamped;
        pend        <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/audio_sample_scheduler.sv
// Paces samples from a valid/ready producer to a DAC at a programmable rate.
// Holds the run FSM, the one-entry prefetch buffer and underrun statistics.
module audio_sample_scheduler
  import audio_pkg::*;
#(
  parameter int unsigned DIV_W       = 16,
  parameter int unsigned SAMPLE_W    = 16,
  parameter int unsigned DEFAULT_DIV = DIV_44K1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [DIV_W-1:0]    div_in,
  input  logic                div_load,
  output logic                div_busy,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [SAMPLE_W-1:0] s_data,
  output logic [SAMPLE_W-1:0] sample_out,
  output logic                sample_strobe,
  output logic                underrun,
  output logic [7:0]          underrun_count,
  output logic                running
);

  state_t              state;
  logic                buf_full;
  logic [SAMPLE_W-1:0] buf_data;
  logic                tick;
  logic                xfer;

  assign running = (state == ST_RUN);
  assign s_ready = running && !buf_full;
  assign xfer    = s_valid && s_ready;

  sample_rate_divider #(
    .DIV_W       (DIV_W),
    .DEFAULT_DIV (DEFAULT_DIV)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .run      (running),
    .div_in   (div_in),
    .div_load (div_load),
    .tick     (tick),
    .div_busy (div_busy)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ST_IDLE;
      buf_full       <= 1'b0;
      buf_data       <= '0;
      sample_out     <= '0;
      sample_strobe  <= 1'b0;
      underrun       <= 1'b0;
      underrun_count <= '0;
    end else begin
      sample_strobe <= 1'b0;
      underrun      <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          buf_full <= 1'b0;
          if (enable) begin
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (xfer) begin
            buf_full <= 1'b1;
            buf_data <= s_data;
          end
          // A sample landing on the tick itself is too late for this tick.
          if (tick) begin
            if (buf_full) begin
              sample_out    <= buf_data;
              sample_strobe <= 1'b1;
              buf_full      <= 1'b0;
            end else begin
              underrun <= 1'b1;
              if (underrun_count != 8'hFF) begin
                underrun_count <= underrun_count + 8'd1;
              end
            end
          end
          if (!enable) begin
            state    <= ST_IDLE;
            buf_full <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule
